// File: rtl/axi_lite_pkg.sv
// Shared response codes, FSM state encodings and address decode helper for the
// AXI4-Lite SRAM responder.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_RESP = 2'd2
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_WAIT = 2'd1,
      W_RESP = 2'd2
   } wr_state_t;

   typedef struct packed {
      rd_state_t rd_state;
      wr_state_t wr_state;
   } fsm_debug_t;

   // The subtraction wraps, so addresses below base land far above the window.
   function automatic logic addr_in_range(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input int unsigned depth);
      logic [31:0] offset;
      offset = addr - base;
      return offset < 32'(4 * depth);
   endfunction

endpackage

// File: rtl/axi_lite_sram_slave_if.sv
// AXI4-Lite signal bundle between a bus master and the SRAM responder.
interface axi_lite_sram_slave_if;

   // A transfer completes on a rising clock edge where valid and ready are both
   // high; valid, once raised, holds with a stable payload until that edge.
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

endinterface

// File: rtl/axi_lite_sram_slave_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to randomise responder latency and
// ready gaps; loads the seed while reset is high.
module lfsr8 (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] seed,
   input  logic       enable,
   output logic [7:0] state
);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= seed;
      end else if (enable) begin
         state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
      end
   end

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite responder over a word-addressed SRAM with independent read/write
// FSMs and fixed latencies; define AXI_SRAM_RAND_DELAY_EN for LFSR-driven latency.
module axi_lite_sram_slave
   import axi_lite_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned WR_LATENCY = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   axi_lite_sram_slave_if.slave bus,
   output fsm_debug_t           debug
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [31:0] mem [DEPTH];

   rd_state_t        r_state, r_next;
   wr_state_t        w_state, w_next;
   logic [3:0]       r_cnt, w_cnt;
   logic [IDX_W-1:0] r_index, w_index;
   logic             r_hit, w_hit;
   logic [31:0]      w_data;
   logic [3:0]       w_strb;
   logic             aw_done, w_done;
   logic [31:0]      rdata_q;
   logic [1:0]       rresp_q, bresp_q;
   logic [3:0]       rd_lat, wr_lat;
   logic             ready_gate;

`ifdef AXI_SRAM_RAND_DELAY_EN
   logic [7:0] lfsr;

   lfsr8 u_lfsr (
      .clock  (clock),
      .reset  (reset),
      .seed   (8'hA5),
      .enable (1'b1),
      .state  (lfsr)
   );

   assign rd_lat     = lfsr[3:0];
   assign wr_lat     = lfsr[3:0];
   assign ready_gate = ~lfsr[7];
`else
   assign rd_lat     = 4'(RD_LATENCY);
   assign wr_lat     = 4'(WR_LATENCY);
   assign ready_gate = 1'b1;
`endif

   logic ar_hs, aw_hs, w_hs, aw_have, w_have, r_sample, w_commit;

   // Readies drop combinationally with reset so nothing is accepted during it.
   assign bus.arready = ~reset & ready_gate & (r_state == R_IDLE);
   assign bus.awready = ~reset & ready_gate & (w_state == W_IDLE) & ~aw_done;
   assign bus.wready  = ~reset & ready_gate & (w_state == W_IDLE) & ~w_done;
   assign bus.rvalid  = (r_state == R_RESP);
   assign bus.bvalid  = (w_state == W_RESP);
   assign bus.rdata   = rdata_q;
   assign bus.rresp   = rresp_q;
   assign bus.bresp   = bresp_q;

   assign ar_hs    = bus.arvalid & bus.arready;
   assign aw_hs    = bus.awvalid & bus.awready;
   assign w_hs     = bus.wvalid & bus.wready;
   assign aw_have  = aw_done | aw_hs;
   assign w_have   = w_done | w_hs;
   assign r_sample = (r_state == R_WAIT) && (r_cnt == 4'd0);
   assign w_commit = (w_state == W_WAIT) && (w_cnt == 4'd0);

   assign debug.rd_state = r_state;
   assign debug.wr_state = w_state;

   always_comb begin
      r_next = r_state;
      w_next = w_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_WAIT;
         R_WAIT:  if (r_cnt == 4'd0) r_next = R_RESP;
         R_RESP:  if (bus.rready) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
      case (w_state)
         W_IDLE:  if (aw_have && w_have) w_next = W_WAIT;
         W_WAIT:  if (w_cnt == 4'd0) w_next = W_RESP;
         W_RESP:  if (bus.bready) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= R_IDLE;
         w_state <= W_IDLE;
         r_cnt   <= 4'd0;
         w_cnt   <= 4'd0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         rdata_q <= 32'd0;
         rresp_q <= RESP_OKAY;
         bresp_q <= RESP_OKAY;
      end else begin
         r_state <= r_next;
         w_state <= w_next;
         if (ar_hs) begin
            r_cnt   <= rd_lat;
            r_hit   <= addr_in_range(bus.araddr, BASE_ADDR, DEPTH);
            r_index <= IDX_W'((bus.araddr - BASE_ADDR) >> 2);
         end else if (r_state == R_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (r_sample) begin
            rdata_q <= r_hit ? mem[r_index] : 32'd0;
            rresp_q <= r_hit ? RESP_OKAY : RESP_SLVERR;
         end
         if (aw_hs) begin
            aw_done <= 1'b1;
            w_hit   <= addr_in_range(bus.awaddr, BASE_ADDR, DEPTH);
            w_index <= IDX_W'((bus.awaddr - BASE_ADDR) >> 2);
         end
         if (w_hs) begin
            w_done <= 1'b1;
            w_data <= bus.wdata;
            w_strb <= bus.wstrb;
         end
         // Both halves present: flags clear here, overriding the sets above.
         if (w_state == W_IDLE && aw_have && w_have) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            w_cnt   <= wr_lat;
         end else if (w_state == W_WAIT && w_cnt != 4'd0) begin
            w_cnt <= w_cnt - 4'd1;
         end
         if (w_commit) begin
            bresp_q <= w_hit ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   // Non-blocking commit means a same-cycle read sample sees the old word.
   always_ff @(posedge clock) begin
      if (!reset && w_commit && w_hit) begin
         for (int i = 0; i < 4; i++) begin
            if (w_strb[i]) mem[w_index][8*i +: 8] <= w_data[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed bench for axi_lite_sram_slave: a cycle-level transaction model
// predicts handshakes, latencies and data; literal checks pin the model.
module tb_axi_lite_sram_slave;
   import axi_lite_pkg::*;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 1024;
   localparam int          RL    = 1;
   localparam int          WL    = 1;
   localparam int          TMO   = 60;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   axi_lite_sram_slave_if bus ();
   fsm_debug_t dbg;

   axi_lite_sram_slave #(
      .BASE_ADDR  (BASE),
      .DEPTH      (DEPTH),
      .RD_LATENCY (RL),
      .WR_LATENCY (WL)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .debug (dbg)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   function automatic void check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: no handshake within %0d cycles, required one", name, TMO);
   endtask

   // ---------------- behavioural model / scoreboard ----------------
   logic [31:0] mem_m [int];
   logic [33:0] exp_q [$];
   bit          started = 0;
   bit          rd_busy = 0, wr_busy = 0, aw_got = 0, w_got = 0;
   int          rd_samp_c, rd_val_c, wr_com_c, wr_val_c;
   logic [31:0] rd_addr_m, wr_addr_m, wr_data_m;
   logic [3:0]  wr_strb_m;
   logic [1:0]  exp_bresp;

   function automatic bit in_rng(input logic [31:0] a);
      longint unsigned x, lo;
      x  = {32'd0, a};
      lo = {32'd0, BASE};
      return (x >= lo) && (x < lo + 64'(4 * DEPTH));
   endfunction

   function automatic int idx_of(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   // End of cycle c: accept requests, sample reads, then commit writes.
   always @(posedge clock) begin
      int c;
      logic [31:0] w;
      c = cyc;
      if (reset) begin
         started = 1;
         rd_busy = 0;
         wr_busy = 0;
         aw_got  = 0;
         w_got   = 0;
         exp_q.delete();
      end else if (started) begin
         if (!rd_busy && bus.arvalid) begin
            rd_busy   = 1;
            rd_addr_m = bus.araddr;
            rd_samp_c = c + RL + 1;
            rd_val_c  = c + RL + 2;
         end
         if (rd_busy && c == rd_samp_c) begin
            if (in_rng(rd_addr_m))
               exp_q.push_back({RESP_OKAY, mem_m.exists(idx_of(rd_addr_m)) ? mem_m[idx_of(rd_addr_m)] : 32'hxxxx_xxxx});
            else
               exp_q.push_back({RESP_SLVERR, 32'd0});
         end
         if (rd_busy && c >= rd_val_c && bus.rready) begin
            rd_busy = 0;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         if (!wr_busy && !aw_got && bus.awvalid) begin
            aw_got    = 1;
            wr_addr_m = bus.awaddr;
         end
         if (!wr_busy && !w_got && bus.wvalid) begin
            w_got     = 1;
            wr_data_m = bus.wdata;
            wr_strb_m = bus.wstrb;
         end
         if (!wr_busy && aw_got && w_got) begin
            wr_busy  = 1;
            wr_com_c = c + WL + 1;
            wr_val_c = c + WL + 2;
         end
         if (wr_busy && c == wr_com_c) begin
            if (in_rng(wr_addr_m)) begin
               w = mem_m.exists(idx_of(wr_addr_m)) ? mem_m[idx_of(wr_addr_m)] : 32'hxxxx_xxxx;
               for (int b = 0; b < 4; b++)
                  if (wr_strb_m[b]) w[8*b +: 8] = wr_data_m[8*b +: 8];
               mem_m[idx_of(wr_addr_m)] = w;
               exp_bresp = RESP_OKAY;
            end else begin
               exp_bresp = RESP_SLVERR;
            end
         end
         if (wr_busy && c >= wr_val_c && bus.bready) begin
            wr_busy = 0;
            aw_got  = 0;
            w_got   = 0;
         end
      end
      cyc = cyc + 1;
   end

   // Compare process: every cycle once reset has been seen.
   always @(negedge clock) begin
      if (started) begin
         check_bit("arready", bus.arready, !reset && !rd_busy);
         check_bit("awready", bus.awready, !reset && !wr_busy && !aw_got);
         check_bit("wready", bus.wready, !reset && !wr_busy && !w_got);
         check_bit("rvalid", bus.rvalid, rd_busy && cyc >= rd_val_c);
         check_bit("bvalid", bus.bvalid, wr_busy && cyc >= wr_val_c);
         if (rd_busy && cyc >= rd_val_c) begin
            if (exp_q.size() == 0) begin
               timeout_fail("exp_q_empty");
            end else begin
               check_word("rdata", bus.rdata, exp_q[0][31:0]);
               check_word("rresp", 32'(bus.rresp), 32'(exp_q[0][33:32]));
            end
         end
         if (wr_busy && cyc >= wr_val_c)
            check_word("bresp", 32'(bus.bresp), 32'(exp_bresp));
      end
   end

   // ---------------- driver tasks (start and end just after a rising edge) ----------------
   task automatic do_read(input logic [31:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp,
                          output int ar_c, output int rv_c, output int rhs_c);
      int n;
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      bus.rready  = 1'b0;
      n = 0;
      @(negedge clock);
      while (!bus.arready && n < TMO) begin @(negedge clock); n++; end
      if (!bus.arready) timeout_fail("ar_wait");
      ar_c = cyc;
      @(posedge clock); #1;
      bus.arvalid = 1'b0;
      n = 0;
      @(negedge clock);
      while (!bus.rvalid && n < TMO) begin @(negedge clock); n++; end
      if (!bus.rvalid) timeout_fail("r_wait");
      rv_c = cyc;
      data = bus.rdata;
      resp = bus.rresp;
      repeat (hold) @(negedge clock);
      #1;
      bus.rready = 1'b1;
      rhs_c = cyc;
      @(posedge clock); #1;
      bus.rready = 1'b0;
   endtask

   task automatic send_aw(input logic [31:0] addr, input int delay, output int hs_c);
      int n;
      repeat (delay) begin @(posedge clock); #1; end
      bus.awaddr  = addr;
      bus.awvalid = 1'b1;
      n = 0;
      @(negedge clock);
      while (!bus.awready && n < TMO) begin @(negedge clock); n++; end
      if (!bus.awready) timeout_fail("aw_wait");
      hs_c = cyc;
      @(posedge clock); #1;
      bus.awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int delay, output int hs_c);
      int n;
      repeat (delay) begin @(posedge clock); #1; end
      bus.wdata  = data;
      bus.wstrb  = strb;
      bus.wvalid = 1'b1;
      n = 0;
      @(negedge clock);
      while (!bus.wready && n < TMO) begin @(negedge clock); n++; end
      if (!bus.wready) timeout_fail("w_wait");
      hs_c = cyc;
      @(posedge clock); #1;
      bus.wvalid = 1'b0;
   endtask

   task automatic wait_b(output logic [1:0] resp, output int b_c);
      int n;
      n = 0;
      @(negedge clock);
      while (!bus.bvalid && n < TMO) begin @(negedge clock); n++; end
      if (!bus.bvalid) timeout_fail("b_wait");
      b_c  = cyc;
      resp = bus.bresp;
      #1;
      bus.bready = 1'b1;
      @(posedge clock); #1;
      bus.bready = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_delay, input int aw_delay,
                           output logic [1:0] resp, output int m, output int b_c);
      int aw_c, w_c;
      fork
         send_aw(addr, aw_delay, aw_c);
         send_w(data, strb, w_delay, w_c);
      join
      m = (aw_c > w_c) ? aw_c : w_c;
      wait_b(resp, b_c);
   endtask

   // ---------------- directed sequence ----------------
   logic [31:0] d;
   logic [1:0]  r, br;
   int          ac, rc, hc, ac2, rc2, hc2, m, bc, aw_c, w_c;

   initial begin
      bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
      bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
      bus.bready = 0;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_bit("rst_arready", bus.arready, 1'b0);
      check_bit("rst_rvalid", bus.rvalid, 1'b0);
      check_word("rst_rdata", bus.rdata, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check_bit("post_rst_arready", bus.arready, 1'b1);
      check_bit("post_rst_awready", bus.awready, 1'b1);
      check_bit("post_rst_wready", bus.wready, 1'b1);
      check_word("post_rst_rd_state", 32'(dbg.rd_state), 32'(R_IDLE));
      @(posedge clock); #1;

      // Full-word write then read back
      do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, br, m, bc);
      check_word("wr1_bresp", 32'(br), 32'd0);
      check_int("wr1_bvalid_lat", bc - m, 3);
      do_read(BASE + 32'h10, 0, d, r, ac, rc, hc);
      check_word("rd1_data", d, 32'hDEAD_BEEF);
      check_word("rd1_rresp", 32'(r), 32'd0);
      check_int("rd1_rvalid_lat", rc - ac, 3);

      // W leads AW by three cycles, partial strobes
      do_write(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, br, m, bc);
      fork
         send_aw(BASE + 32'h20, 3, aw_c);
         send_w(32'h1122_3344, 4'b0101, 0, w_c);
      join
      check_int("wlead_gap", aw_c - w_c, 3);
      wait_b(br, bc);
      check_int("wlead_bvalid_lat", bc - aw_c, 3);
      check_word("wlead_bresp", 32'(br), 32'd0);
      do_read(BASE + 32'h20, 0, d, r, ac, rc, hc);
      check_word("strb_merge_data", d, 32'hFF22_FF44);

      // Zero strobe leaves the word alone
      do_write(BASE + 32'h10, 32'h0000_0000, 4'h0, 0, 0, br, m, bc);
      check_word("strb0_bresp", 32'(br), 32'd0);
      do_read(BASE + 32'h10, 0, d, r, ac, rc, hc);
      check_word("strb0_data", d, 32'hDEAD_BEEF);

      // Out-of-range read and write
      do_write(BASE + 32'hFFC, 32'h0BAD_F00D, 4'hF, 0, 0, br, m, bc);
      do_read(32'h8000_1000, 0, d, r, ac, rc, hc);
      check_word("oor_rd_data", d, 32'd0);
      check_word("oor_rd_rresp", 32'(r), 32'd2);
      do_write(32'h7FFF_FFFC, 32'h1234_5678, 4'hF, 0, 0, br, m, bc);
      check_word("oor_wr_bresp", 32'(br), 32'd2);
      do_read(BASE + 32'hFFC, 0, d, r, ac, rc, hc);
      check_word("oor_wr_nochange", d, 32'h0BAD_F00D);

      // Backpressure on R, then immediate next read
      do_read(BASE + 32'h20, 5, d, r, ac, rc, hc);
      check_word("hold_data", d, 32'hFF22_FF44);
      check_int("hold_len", hc - rc, 5);
      do_read(BASE + 32'h10, 0, d, r, ac2, rc2, hc2);
      check_int("next_ar_after_r", ac2, hc + 1);
      check_word("next_rd_data", d, 32'hDEAD_BEEF);

      // Read sample and write commit in the same cycle
      do_write(BASE + 32'h30, 32'hAAAA_5555, 4'hF, 0, 0, br, m, bc);
      fork
         do_read(BASE + 32'h30, 0, d, r, ac, rc, hc);
         do_write(BASE + 32'h30, 32'h5555_AAAA, 4'hF, 0, 0, br, m, bc);
      join
      check_int("same_cycle_accept", ac, m);
      check_word("same_cycle_old", d, 32'hAAAA_5555);
      do_read(BASE + 32'h30, 0, d, r, ac, rc, hc);
      check_word("same_cycle_new", d, 32'h5555_AAAA);

      // Reset while a write waits to commit
      fork
         send_aw(BASE + 32'h10, 0, aw_c);
         send_w(32'hCAFE_F00D, 4'hF, 0, w_c);
      join
      reset = 1'b1;
      @(negedge clock);
      check_bit("midrst_arready", bus.arready, 1'b0);
      check_bit("midrst_awready", bus.awready, 1'b0);
      check_bit("midrst_wready", bus.wready, 1'b0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check_bit("rel_arready", bus.arready, 1'b1);
      check_bit("rel_awready", bus.awready, 1'b1);
      check_bit("rel_wready", bus.wready, 1'b1);
      check_bit("rel_bvalid", bus.bvalid, 1'b0);
      check_word("rel_rdata", bus.rdata, 32'd0);
      check_word("rel_bresp", 32'(bus.bresp), 32'd0);
      @(posedge clock); #1;
      do_read(BASE + 32'h10, 0, d, r, ac, rc, hc);
      check_word("no_commit_after_rst", d, 32'hDEAD_BEEF);

      repeat (3) @(posedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run still active at time limit, required to finish");
      $fatal(1, "watchdog expired");
   end

endmodule
